pbus_io_ctrl: RTL
=================

// Module: pbus_io_ctrl
// PURPOSE
//  Parametrised PBus I/O controller; successor to the fixed 16-LED/16-switch/5-button controller.
//  Adds per-channel debounce, a button rising-edge capture register (W1C), switch-change capture,
//  a masked interrupt output and configurable PBus wait states. Sits between board pins, the COP
//  debug port and the CPU PBus. Seven-seg driving stays in the existing io_ssd instance.
// PARAMETERS
//  N_LED        16  LED channels, 1..16
//  N_SW         16  switch channels, 1..16
//  N_BTN         5  button channels, 1..16
//  DEB_CYCLES    4  cycles an input must hold a new value before it is accepted; >=1; 1 = no filter
//  WAIT_STATES   1  busy cycles per PBus access, 1..15
// PORTS
//  clk             in   1      system clock
//  rst_l           in   1      asynchronous active-low reset
//  i_buttons       in   N_BTN  raw buttons, asynchronous
//  i_switches      in   N_SW   raw switches, asynchronous
//  o_leds          out  N_LED  LED drive
//  o_ssds          out  16     seven-seg drive, from io_ssd
//  buttonsCOP      out  N_BTN  debounced button level
//  switchesCOP     out  N_SW   debounced switch level
//  ledsCOP         in   N_LED  COP LED value
//  ssdsCOP         in   32     COP seven-seg digits
//  output_override in   1      1: LED and SSD outputs come from the COP inputs
//  PBusAddr        in   [5:1]  word address
//  PBusDataIn      in   16     write data
//  PBusDataOut     out  16     read data
//  PBusReq         in   2      [0] request; [1] 1 = read, 0 = write
//  PBusBE          in   2      byte enables: [0] = bits 7:0, [1] = bits 15:8
//  PBusRdy         out  1      controller ready / access complete
//  irq             out  1      |(btn_edge & btn_mask) | (|sw_chg & sw_ie)
// BEHAVIOUR
//  Reset: all registers 0, FSM IDLE, PBusRdy=1, irq=0. Debounced levels reset to 0.
//   Reset mid-access aborts it; no write occurs.
//  Register map (word address):
//   00 ssd[15:0] RW; 01 ssd[31:16] RW; 02 leds RW; 04 btn level RO
//   05 btn_edge W1C; 06 sw level RO; 07 sw_chg W1C; 08 btn_mask RW
//   09 ctrl RW (bit0 = sw_ie); others read 0, writes ignored
//   Unused upper bits read 0.
//  Register writes: BE applies per byte to all RW and W1C registers. Writes to RO addresses are ignored.
//  Reads: PBusDataOut is combinational from PBusAddr and current register values.
//  FSM states are IDLE, WAIT and DONE:
//   IDLE: PBusReq[0]=1 moves to WAIT and loads wcnt=WAIT_STATES-1.
//   WAIT: wcnt=0 moves to DONE; otherwise wcnt decrements.
//   DONE: always returns to IDLE.
//   PBusRdy=1 in IDLE and DONE.
//   A write commits on the clock edge leaving WAIT with wcnt=0, using Addr/Data/BE sampled then.
//   The master holds Addr/Data/BE from request until PBusRdy.
//   Requests in WAIT or DONE are ignored; no queueing.
//   WAIT_STATES=1 gives the legacy timing: IDLE, one busy cycle, DONE.
//  Debounce, per channel:
//   Inputs pass a 2-flop synchroniser, then a counter of width clog2(DEB_CYCLES)+1.
//   If sync != stable, the counter increments and stable<=sync when count==DEB_CYCLES-1.
//   If sync == stable, the counter clears. A glitch shorter than DEB_CYCLES is never accepted.
//   Latency from pin to level: 2 + DEB_CYCLES cycles.
//  Capture:
//   A 0->1 transition of a debounced button sets btn_edge[i]. Any transition of a switch sets sw_chg[i].
//   A W1C write clears bits written as 1. If set and clear hit the same bit in one cycle, set wins.
//   Bits stay set until cleared.
//  irq is registered: it is updated the cycle after any capture or mask change.
//  Outputs: o_leds = override ? ledsCOP : leds. io_ssd digits = override ? ssdsCOP : ssd.
//   Override does not alter register contents.
// TESTING (bench uses DEB_CYCLES=4, WAIT_STATES=3)
//  1. Write 0xA5C3 to addr 02 with BE=01 -> o_leds=0x00C3.
//     PBusRdy low for exactly 3 cycles, then the DONE cycle.
//  2. Pulse i_buttons[2] high for 3 cycles -> level and btn_edge unchanged.
//     Hold 10 cycles -> buttonsCOP[2]=1 at cycle 6, read 05 = 0x0004.
//  3. btn_mask=0x0004 plus case 2 -> irq=1.
//     Write 0x0004 to 05 in the same cycle a new edge arrives -> bit stays 1, irq stays 1.
//  4. Toggle i_switches[15] with sw_ie=1 -> read 07 = 0x8000, irq=1.
//     W1C 0x8000 -> read 07 = 0, irq=0.
//  5. Assert rst_l=0 in WAIT of a write to 00 -> ssd unchanged (0), PBusRdy=1, irq=0.
//  6. output_override=1 with ledsCOP=0x1234 -> o_leds=0x1234 while reg 02 still reads its old value.

Source files
------------

// File: rtl/pbus_io_ctrl.sv
// pbus_io_ctrl: parametrised PBus I/O controller.
//  Debounces buttons/switches, captures button rising edges and switch changes
//  in W1C registers, raises a masked registered irq, drives LEDs and the
//  seven-seg scanner, and serves a small register file over PBus with
//  programmable wait states.
// Ports:
//  clk, rst_l                     clock, async active-low reset
//  i_buttons/i_switches           raw pins (async)
//  o_leds/o_ssds                  LED drive, seven-seg drive
//  buttonsCOP/switchesCOP         debounced levels to the COP
//  ledsCOP/ssdsCOP/output_override COP takeover of LED/SSD outputs
//  PBusAddr/DataIn/DataOut/Req/BE/Rdy  CPU bus
//  irq                            masked capture interrupt

// One debounce lane: 2-flop synchroniser plus hold counter.
module pbus_io_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic pin,
  output logic lvl,
  output logic tgl,   // level accepted a new value this edge
  output logic rise   // accepted value is a 0->1
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic s1, s2, stable;
  logic [CW-1:0] cnt;

  assign lvl  = stable;
  assign tgl  = (s2 != stable) && (cnt == CMAX);
  assign rise = tgl & s2;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1 <= 1'b0; s2 <= 1'b0; stable <= 1'b0; cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 != stable) begin
        if (cnt == CMAX) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// io_ssd: scans four digits; each digit is an 8-bit segment pattern.
//  ssds = {segments[7:0], 4'hF, anodes_l[3:0]}.
module io_ssd (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [31:0] digits,
  output logic [15:0] ssds
);
  logic [17:0] scan;
  logic [1:0]  sel;

  assign sel  = scan[17:16];
  assign ssds = {digits[{sel, 3'b000} +: 8], 4'hF, ~(4'b0001 << sel)};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) scan <= '0;
    else        scan <= scan + 1'b1;
  end
endmodule

module pbus_io_ctrl #(
  parameter int N_LED       = 16,
  parameter int N_SW        = 16,
  parameter int N_BTN       = 5,
  parameter int DEB_CYCLES  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [N_BTN-1:0] i_buttons,
  input  logic [N_SW-1:0]  i_switches,
  output logic [N_LED-1:0] o_leds,
  output logic [15:0]      o_ssds,
  output logic [N_BTN-1:0] buttonsCOP,
  output logic [N_SW-1:0]  switchesCOP,
  input  logic [N_LED-1:0] ledsCOP,
  input  logic [31:0]      ssdsCOP,
  input  logic             output_override,
  input  logic [5:1]       PBusAddr,
  input  logic [15:0]      PBusDataIn,
  output logic [15:0]      PBusDataOut,
  input  logic [1:0]       PBusReq,
  input  logic [1:0]       PBusBE,
  output logic             PBusRdy,
  output logic             irq
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t     state, state_d;
  logic [3:0] wcnt, wcnt_d;
  logic       wr_q, wr_d;
  logic       wr_en;
  logic [15:0] wmask, w1c;

  logic [15:0]      ssd_lo, ssd_hi;
  logic [N_LED-1:0] leds;
  logic [N_BTN-1:0] btn_edge, btn_mask, btn_rise, btn_tgl, btn_clr;
  logic [N_SW-1:0]  sw_chg, sw_tgl, sw_rise, sw_clr;
  logic             sw_ie;

  // Debounce lanes
  pbus_io_deb #(.DEB_CYCLES(DEB_CYCLES)) u_btn_deb [N_BTN-1:0] (
    .clk(clk), .rst_l(rst_l), .pin(i_buttons),
    .lvl(buttonsCOP), .tgl(btn_tgl), .rise(btn_rise));
  pbus_io_deb #(.DEB_CYCLES(DEB_CYCLES)) u_sw_deb [N_SW-1:0] (
    .clk(clk), .rst_l(rst_l), .pin(i_switches),
    .lvl(switchesCOP), .tgl(sw_tgl), .rise(sw_rise));

  // Bus FSM
  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    wr_d    = wr_q;
    case (state)
      S_IDLE: if (PBusReq[0]) begin
        state_d = S_WAIT;
        wcnt_d  = 4'(WAIT_STATES - 1);
        wr_d    = ~PBusReq[1];
      end
      S_WAIT: if (wcnt == 4'd0) state_d = S_DONE;
              else              wcnt_d  = wcnt - 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= S_IDLE; wcnt <= '0; wr_q <= 1'b0;
    end else begin
      state <= state_d; wcnt <= wcnt_d; wr_q <= wr_d;
    end
  end

  assign PBusRdy = (state != S_WAIT);
  assign wr_en   = (state == S_WAIT) && (wcnt == 4'd0) && wr_q;
  assign wmask   = {{8{PBusBE[1]}}, {8{PBusBE[0]}}};
  assign w1c     = PBusDataIn & wmask;
  assign btn_clr = (wr_en && PBusAddr == 5'd5) ? N_BTN'(w1c) : '0;
  assign sw_clr  = (wr_en && PBusAddr == 5'd7) ? N_SW'(w1c)  : '0;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic [15:0] m);
    return (old & ~m) | (din & m);
  endfunction

  // Register file; capture set has priority over a simultaneous W1C clear
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ssd_lo <= '0; ssd_hi <= '0; leds <= '0; btn_mask <= '0; sw_ie <= 1'b0;
      btn_edge <= '0; sw_chg <= '0; irq <= 1'b0;
    end else begin
      if (wr_en) begin
        case (PBusAddr)
          5'd0: ssd_lo   <= merge(ssd_lo, PBusDataIn, wmask);
          5'd1: ssd_hi   <= merge(ssd_hi, PBusDataIn, wmask);
          5'd2: leds     <= N_LED'(merge(16'(leds), PBusDataIn, wmask));
          5'd8: btn_mask <= N_BTN'(merge(16'(btn_mask), PBusDataIn, wmask));
          5'd9: if (PBusBE[0]) sw_ie <= PBusDataIn[0];
          default: ;
        endcase
      end
      btn_edge <= (btn_edge & ~btn_clr) | btn_rise;
      sw_chg   <= (sw_chg & ~sw_clr) | sw_tgl;
      irq      <= (|(btn_edge & btn_mask)) | ((|sw_chg) & sw_ie);
    end
  end

  // Combinational read mux
  always_comb begin
    PBusDataOut = '0;
    case (PBusAddr)
      5'd0: PBusDataOut = ssd_lo;
      5'd1: PBusDataOut = ssd_hi;
      5'd2: PBusDataOut = 16'(leds);
      5'd4: PBusDataOut = 16'(buttonsCOP);
      5'd5: PBusDataOut = 16'(btn_edge);
      5'd6: PBusDataOut = 16'(switchesCOP);
      5'd7: PBusDataOut = 16'(sw_chg);
      5'd8: PBusDataOut = 16'(btn_mask);
      5'd9: PBusDataOut = {15'd0, sw_ie};
      default: ;
    endcase
  end

  // Switch rising edges carry no extra meaning; any transition is a change.
  logic unused_sw_rise;
  assign unused_sw_rise = ^sw_rise;

  assign o_leds = output_override ? ledsCOP : leds;

  io_ssd u_io_ssd (
    .clk(clk), .rst_l(rst_l),
    .digits(output_override ? ssdsCOP : {ssd_hi, ssd_lo}),
    .ssds(o_ssds));
endmodule
